// File: rtl/id_decode_hz.sv
// id_decode_hz: decode stage with integrated register file, WB write-through
// bypass, load-use stall, flush squash, sticky HALT and per-class counters.
module id_decode_hz #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 16,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  input  logic [31:0]                inst,
  input  logic [31:0]                pc4_in,
  output logic                       id_stall,
  input  logic                       ex_flush,
  input  logic                       wb_we,
  input  logic [REG_AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       ex_valid,
  output logic                       ex_branch,
  output logic                       ex_mem_read,
  output logic                       ex_mem_write,
  output logic                       ex_reg_write,
  output logic [5:0]                 ex_opcode,
  output logic [DATA_W-1:0]          ex_rs_val,
  output logic [DATA_W-1:0]          ex_rt_val,
  output logic [DATA_W-1:0]          ex_imm,
  output logic [REG_AW-1:0]          ex_rs_addr,
  output logic [REG_AW-1:0]          ex_rt_addr,
  output logic [REG_AW-1:0]          ex_rd_addr,
  output logic [31:0]                ex_pc4,
  output logic                       halted,
  output logic [CNT_W-1:0]           arith_cnt,
  output logic [CNT_W-1:0]           logic_cnt,
  output logic [CNT_W-1:0]           mem_cnt,
  output logic [CNT_W-1:0]           ctrl_cnt,
  output logic [NUM_REGS*DATA_W-1:0] regs_out
);

  typedef struct packed {
    logic                valid;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic [5:0]          opcode;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [DATA_W-1:0]   imm;
    logic [REG_AW-1:0]   rs_addr;
    logic [REG_AW-1:0]   rt_addr;
    logic [REG_AW-1:0]   rd_addr;
    logic [31:0]         pc4;
  } ex_t;

  localparam logic [5:0] OP_LDW = 6'd12, OP_STW = 6'd13, OP_BZ = 6'd14,
                         OP_BEQ = 6'd15, OP_JR = 6'd16, OP_HALT = 6'd17, OP_NOP = 6'd63;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  ex_t               ex_q, ex_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  arith_q, arith_d, logic_q, logic_d, mem_q, mem_d, ctrl_q, ctrl_d;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm_sx, rs_rd, rt_rd;
  logic              is_r, is_i, is_ldw, is_stw, is_br, is_halt, is_nop, legal;
  logic              use_rs, use_rt, hazard, accepted, issue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Field extraction, class decode and bypassed operand reads.
  always_comb begin
    op      = inst[31:26];
    rs      = inst[21 +: REG_AW];
    rt      = inst[16 +: REG_AW];
    rd      = inst[11 +: REG_AW];
    imm_sx  = DATA_W'($signed(inst[15:0]));
    is_r    = (op <= 6'd10) && !op[0];
    is_i    = (op <= 6'd11) && op[0];
    is_ldw  = (op == OP_LDW);
    is_stw  = (op == OP_STW);
    is_br   = (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
    is_halt = (op == OP_HALT);
    is_nop  = (op == OP_NOP);
    legal   = (op <= OP_HALT) || is_nop;
    use_rs  = is_r || is_i || is_ldw || is_stw || is_br;
    use_rt  = is_r || is_stw || (op == OP_BEQ);
    // R0 is hard zero; a same-cycle WB write to the source wins over the array.
    rs_rd = regs_q[rs];
    if (rs == '0) rs_rd = '0;
    else if (wb_we && wb_addr == rs) rs_rd = wb_data;
    rt_rd = regs_q[rt];
    if (rt == '0) rt_rd = '0;
    else if (wb_we && wb_addr == rt) rt_rd = wb_data;
  end

  // Load-use detection; flush and halt both cancel the stall.
  always_comb begin
    hazard   = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
               ((use_rs && rs == ex_q.rd_addr) || (use_rt && rt == ex_q.rd_addr));
    id_stall = if_valid && hazard && !ex_flush && !halted_q;
    accepted = if_valid && !id_stall && !ex_flush && !halted_q;
    issue    = accepted && legal && !is_nop;
  end

  // Next EX register, counters, halt flag and register-file write.
  always_comb begin
    ex_d     = '0;
    halted_d = halted_q;
    arith_d  = arith_q;
    logic_d  = logic_q;
    mem_d    = mem_q;
    ctrl_d   = ctrl_q;
    regs_d   = regs_q;
    if (wb_we && wb_addr != '0) regs_d[wb_addr] = wb_data;
    if (issue) begin
      ex_d.valid  = 1'b1;
      ex_d.opcode = op;
      ex_d.pc4    = pc4_in;
      if (!is_halt) begin
        ex_d.rs_addr   = use_rs ? rs : '0;
        ex_d.rs_val    = use_rs ? rs_rd : '0;
        ex_d.rt_addr   = use_rt ? rt : '0;
        ex_d.rt_val    = use_rt ? rt_rd : '0;
        ex_d.imm       = is_r ? '0 : imm_sx;
        ex_d.rd_addr   = is_r ? rd : ((is_i || is_ldw) ? rt : '0);
        ex_d.reg_write = is_r || is_i || is_ldw;
        ex_d.mem_read  = is_ldw;
        ex_d.mem_write = is_stw;
        ex_d.branch    = is_br;
      end
      if (op <= 6'd5)        arith_d = sat_inc(arith_q);
      else if (op <= 6'd11)  logic_d = sat_inc(logic_q);
      else if (op <= OP_STW) mem_d   = sat_inc(mem_q);
      else                   ctrl_d  = sat_inc(ctrl_q);
      if (is_halt) halted_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q   <= '{default: '0};
      ex_q     <= '0;
      halted_q <= 1'b0;
      arith_q  <= '0;
      logic_q  <= '0;
      mem_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      regs_q   <= regs_d;
      ex_q     <= ex_d;
      halted_q <= halted_d;
      arith_q  <= arith_d;
      logic_q  <= logic_d;
      mem_q    <= mem_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_branch    = ex_q.branch;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_opcode    = ex_q.opcode;
  assign ex_rs_val    = ex_q.rs_val;
  assign ex_rt_val    = ex_q.rt_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rs_addr   = ex_q.rs_addr;
  assign ex_rt_addr   = ex_q.rt_addr;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_pc4       = ex_q.pc4;
  assign halted       = halted_q;
  assign arith_cnt    = arith_q;
  assign logic_cnt    = logic_q;
  assign mem_cnt      = mem_q;
  assign ctrl_cnt     = ctrl_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dump
    assign regs_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: tb/tb_id_decode_hz.sv
// Scoreboard bench for id_decode_hz: driver pushes expected EX records,
// a negedge monitor pops one whenever ex_valid is presented.
module tb_id_decode_hz;
  localparam int DW = 32, NR = 32, CW = 4, AW = 5;

  logic          clk = 1'b0, reset = 1'b1;
  logic          if_valid = 1'b0, ex_flush = 1'b0, wb_we = 1'b0;
  logic [31:0]   inst = '0, pc4_in = '0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          id_stall, ex_valid, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, halted;
  logic [5:0]    ex_opcode;
  logic [DW-1:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [AW-1:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [31:0]   ex_pc4;
  logic [CW-1:0] arith_cnt, logic_cnt, mem_cnt, ctrl_cnt;
  logic [NR*DW-1:0] regs_out;

  id_decode_hz #(.DATA_W(DW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .inst(inst), .pc4_in(pc4_in),
    .id_stall(id_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .ex_pc4(ex_pc4), .halted(halted), .arith_cnt(arith_cnt), .logic_cnt(logic_cnt),
    .mem_cnt(mem_cnt), .ctrl_cnt(ctrl_cnt), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic        br, mr, mw, rw;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic exp_t mk(logic [5:0] op, logic br, logic mr, logic mw, logic rw,
                              logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                              logic [4:0] rd, logic [31:0] pc4);
    exp_t e;
    e.op = op; e.br = br; e.mr = mr; e.mw = mw; e.rw = rw;
    e.rs = rs; e.rt = rt; e.imm = imm; e.rd = rd; e.pc4 = pc4;
    return e;
  endfunction

  function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encr(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle, optionally expecting an EX record.
  task automatic issue(logic [31:0] i, logic [31:0] pc, bit expect_out, exp_t e);
    inst = i; pc4_in = pc; if_valid = 1'b1;
    if (expect_out) q.push_back(e);
    cyc();
    if_valid = 1'b0;
  endtask

  // Monitor: compare every presented EX instruction against the scoreboard.
  always @(negedge clk) begin
    exp_t a;
    if (ex_valid === 1'b1) begin
      a = mk(ex_opcode, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write,
             ex_rs_val, ex_rt_val, ex_imm, ex_rd_addr, ex_pc4);
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL ex_unexpected: got %h expected none", a);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL ex_record: got %h expected %h", a, e);
        end
      end
    end
  end

  exp_t none;
  initial begin
    none = '0;
    cyc(); cyc();
    chk("rst_ex_valid", 64'(ex_valid), 0);
    chk("rst_counters", 64'({arith_cnt, logic_cnt, mem_cnt, ctrl_cnt}), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_regs", 64'(|regs_out), 0);
    reset = 1'b0;
    #1 chk("rst_stall", 64'(id_stall), 0);

    // Preload R1=5, R2=7 through WB.
    wb_we = 1; wb_addr = 1; wb_data = 5; cyc();
    wb_addr = 2; wb_data = 7; cyc();
    wb_we = 0;

    // add r3 = r1 + r2
    issue(encr(0, 1, 2, 3), 32'h104, 1, mk(0, 0, 0, 0, 1, 5, 7, 0, 3, 32'h104));
    chk("add_arith_cnt", 64'(arith_cnt), 1);

    // ori r5, r4, 0xFFF0 with R4=0xA5 bypassed from WB the same cycle
    wb_we = 1; wb_addr = 4; wb_data = 32'hA5;
    issue(enc(7, 4, 5, 16'hFFF0), 32'h108, 1, mk(7, 0, 0, 0, 1, 32'hA5, 0, 32'hFFFF_FFF0, 5, 32'h108));
    wb_we = 0;
    chk("ori_logic_cnt", 64'(logic_cnt), 1);
    chk("r4_written", 64'(regs_out[4*32 +: 32]), 32'hA5);

    // LDW r6, 8(r1) then add r7 = r6 + r1: one stall, one bubble
    issue(enc(12, 1, 6, 16'h0008), 32'h10C, 1, mk(12, 0, 1, 0, 1, 5, 0, 8, 6, 32'h10C));
    inst = encr(0, 6, 1, 7); pc4_in = 32'h110; if_valid = 1;
    #1 chk("lu_stall", 64'(id_stall), 1);
    cyc();
    chk("lu_bubble", 64'(ex_valid), 0);
    chk("lu_stall_clear", 64'(id_stall), 0);
    q.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 7, 32'h110));
    cyc(); if_valid = 0;
    chk("lu_mem_cnt", 64'(mem_cnt), 1);
    chk("lu_arith_cnt", 64'(arith_cnt), 2);

    // LDW r8 then dependent add squashed by ex_flush
    issue(enc(12, 2, 8, 16'h0000), 32'h114, 1, mk(12, 0, 1, 0, 1, 7, 0, 0, 8, 32'h114));
    inst = encr(0, 8, 0, 9); pc4_in = 32'h118; if_valid = 1; ex_flush = 1;
    #1 chk("flush_no_stall", 64'(id_stall), 0);
    cyc(); if_valid = 0; ex_flush = 0;
    chk("flush_bubble", 64'(ex_valid), 0);
    chk("flush_counts", 64'({arith_cnt, mem_cnt}), {4'd2, 4'd2});

    // Write to R0 ignored, and not bypassed into add r10 = r0 + r0
    wb_we = 1; wb_addr = 0; wb_data = 32'hFF;
    issue(encr(0, 0, 0, 10), 32'h11C, 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 10, 32'h11C));
    wb_we = 0;
    chk("r0_zero", 64'(regs_out[31:0]), 0);

    // STW, BEQ (negative offset), JR
    issue(enc(13, 1, 2, 16'h0004), 32'h120, 1, mk(13, 0, 0, 1, 0, 5, 7, 4, 0, 32'h120));
    issue(enc(15, 1, 2, 16'hFFFE), 32'h124, 1, mk(15, 1, 0, 0, 0, 5, 7, 32'hFFFF_FFFE, 0, 32'h124));
    issue(enc(16, 2, 1, 16'h0000), 32'h128, 1, mk(16, 1, 0, 0, 0, 7, 0, 0, 0, 32'h128));
    chk("mem_ctrl_cnt", 64'({mem_cnt, ctrl_cnt}), {4'd3, 4'd2});

    // Illegal opcode and NOP: bubbles, not counted
    issue(encr(20, 1, 2, 3), 32'h12C, 0, none);
    chk("illegal_bubble", 64'(ex_valid), 0);
    issue(32'hFC00_0000, 32'h130, 0, none);
    chk("nop_bubble", 64'(ex_valid), 0);
    chk("nop_counts", 64'({arith_cnt, logic_cnt, mem_cnt, ctrl_cnt}), {4'd3, 4'd1, 4'd3, 4'd2});

    // 17 adds: arith saturates at 15
    for (int k = 0; k < 17; k++)
      issue(encr(0, 1, 2, 11), 32'h200 + 32'(4*k), 1, mk(0, 0, 0, 0, 1, 5, 7, 0, 11, 32'h200 + 32'(4*k)));
    chk("arith_sat", 64'(arith_cnt), 15);

    // HALT then add and ori: bubbles, counters frozen, WB still writes
    issue(enc(17, 1, 2, 16'h1234), 32'h300, 1, mk(17, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300));
    chk("halted_set", 64'(halted), 1);
    chk("halt_ctrl_cnt", 64'(ctrl_cnt), 3);
    wb_we = 1; wb_addr = 12; wb_data = 32'h33;
    issue(encr(0, 1, 2, 3), 32'h304, 0, none);
    wb_we = 0;
    chk("halt_bubble", 64'(ex_valid), 0);
    issue(enc(7, 1, 5, 16'h0001), 32'h308, 0, none);
    chk("halt_logic_frozen", 64'(logic_cnt), 1);
    chk("halt_wb_lands", 64'(regs_out[12*32 +: 32]), 32'h33);

    // Reset while halted
    reset = 1; cyc(); reset = 0;
    chk("rst2_halted", 64'(halted), 0);
    chk("rst2_counters", 64'({arith_cnt, logic_cnt, mem_cnt, ctrl_cnt}), 0);
    chk("rst2_regs", 64'(|regs_out), 0);
    chk("rst2_ex_valid", 64'(ex_valid), 0);

    cyc(); cyc();
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_decode_hz.md
# id_decode_hz

Parametrised instruction-decode stage with integrated register file. It decodes one 32-bit instruction per cycle from IF and reads operands with write-through bypass from WB. It detects load-use hazards and stalls IF while inserting an EX bubble, squashes on branch flush, and freezes after HALT. It also keeps saturating per-class instruction counters. It sits between IF and EX, replacing the fixed-width decode stage.

## Interface
Parameters:
- DATA_W, 32, register/operand width (≥16)
- NUM_REGS, 32, register count; legal values 8, 16, 32; REG_AW = $clog2(NUM_REGS)
- CNT_W, 16, instruction-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_valid  in  1  inst/pc4_in valid
- inst  in  32  instruction from IF
- pc4_in  in  32  PC+4 from IF
- id_stall  out  1  hold IF (combinational)
- ex_flush  in  1  squash instruction in ID (taken branch)
- wb_we  in  1  WB write enable
- wb_addr  in  REG_AW  WB destination
- wb_data  in  DATA_W  WB data
- ex_valid, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  EX control
- ex_opcode  out  6
- ex_rs_val, ex_rt_val, ex_imm  out  DATA_W
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  REG_AW  (forwarding/writeback)
- ex_pc4  out  32
- halted  out  1  sticky HALT seen
- arith_cnt, logic_cnt, mem_cnt, ctrl_cnt  out  CNT_W
- regs_out  out  NUM_REGS*DATA_W  flat register dump, reg i at [i*DATA_W +: DATA_W]

## Operation
- Opcode = inst[31:26]. 0–5 arith (add, addi, sub, subi, mul, muli), 6–11 logic (or, ori, and, andi, xor, xori), 12 LDW, 13 STW, 14 BZ, 15 BEQ, 16 JR, 17 HALT, 63 NOP, 18–62 illegal.
- Fields: rs = inst[25:21], rt = inst[20:16], rd = inst[15:11], each truncated to the low REG_AW bits. imm = sign-extend(inst[15:0]) to DATA_W.
- Even opcodes 0–10 are R-type: rs_val = R[rs], rt_val = R[rt], rd_addr = rd, imm = 0, reg_write = 1.
- Odd opcodes 1–11 are I-type: rs_val = R[rs], rt_val = 0, rd_addr = rt, imm, reg_write = 1.
- LDW: as I-type, plus mem_read = 1.
- STW: rs_val and rt_val, imm, rd_addr = 0, mem_write = 1, reg_write = 0.
- BZ and JR: rs_val, rt_val = 0, imm, branch = 1.
- BEQ: rs_val and rt_val, imm, branch = 1.
- Sources used: R-type uses rs and rt; I-type, LDW, BZ and JR use rs; STW and BEQ use rs and rt.
- Register file: R[0] reads 0 and ignores writes. Write occurs when wb_we && wb_addr != 0.
- Read bypass: if wb_we, wb_addr == source and source != 0, the read returns wb_data in the same cycle.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd_addr != 0 && ex_rd_addr equals a used source of inst, with if_valid=1. Then id_stall = 1 and EX loads a bubble.
- Bubble: ex_valid and all control bits 0; data fields 0.
- Accepted = if_valid && !id_stall && !ex_flush && !halted.
- EX register load rules:
  - accepted legal non-NOP instruction: load the decode, ex_valid = 1.
  - otherwise (not accepted, NOP, or illegal): load a bubble.
- ex_flush takes priority over a hazard; id_stall = 0 when ex_flush = 1.
- HALT: when accepted, it passes to EX as valid with all controls 0, increments ctrl_cnt, and sets halted.
- While halted: id_stall = 0, only bubbles issue, counters are frozen, and WB writes still land. halted clears only on reset.
- Counters: on an accepted instruction, increment the class counter (arith 0–5, logic 6–11, mem 12–13, ctrl 14–17). Counters saturate at all-ones. NOP, illegal, stalled and flushed instructions are not counted.

## Timing
- Decode→EX latency 1 cycle; all ex_* outputs are registered.
- id_stall is combinational from inst and the EX register within the same cycle. IF must hold inst/pc4_in while id_stall = 1.
- A load-use stall lasts exactly 1 cycle: the next cycle ex_valid = 0, so the hazard clears.
- WB write at edge N updates R; a same-cycle read before N gets the value via bypass.
- Reset (synchronous, checked at the clock edge, overrides every other event):
  - every ex_* output is 0 and all registers are 0.
  - counters are 0 and halted = 0.
  - id_stall is therefore 0 the cycle after reset.
- Reset mid-stall or mid-halt returns the block to the full reset state on the next edge.

## Test plan
- Reset with DATA_W=32, then add r3 = r1+r2 with R1=5, R2=7 preloaded via WB: next cycle ex_rs_val=5, ex_rt_val=7, ex_rd_addr=3, ex_reg_write=1, arith_cnt=1.
- WB writes R4=0xA5 in the same cycle ID decodes ori r5, r4, 0xFFF0: ex_rs_val=0xA5, ex_imm=0xFFFFFFF0, logic_cnt=1.
- LDW r6 followed by add r7 = r6+r1: id_stall=1 for one cycle, one bubble (ex_valid=0), then add issues; mem_cnt=1, arith_cnt=1.
- Same load-use hazard but ex_flush=1 in the stall cycle: id_stall=0, bubble issues, no counter increments.
- CNT_W=4: 17 arith instructions leave arith_cnt=15. A write to R0 with wb_data=0xFF leaves R0 reading 0.
- HALT followed by add: halted=1, ctrl_cnt=1, add yields a bubble with no count. Reset then clears halted and all counters to 0.
